// File: rtl/wfg_drive_pat_pkg.sv
// Shared types and constants for the drive-pattern sequencer.
package wfg_drive_pat_pkg;

   localparam int unsigned WFG_PAT_SUBCYCLE_CNT_W = 8;
   localparam logic [WFG_PAT_SUBCYCLE_CNT_W-1:0] WFG_PAT_SUBCYCLE_CNT_MAX = 8'hFF;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      WAIT_SYNC = 2'd1,
      RUN       = 2'd2
   } wfg_drive_pat_seq_state_t;

   // Saturating increment of the subcycle counter.
   function automatic logic [WFG_PAT_SUBCYCLE_CNT_W-1:0] sat_inc(
      input logic [WFG_PAT_SUBCYCLE_CNT_W-1:0] v
   );
      if (v == WFG_PAT_SUBCYCLE_CNT_MAX) return v;
      return v + WFG_PAT_SUBCYCLE_CNT_W'(1);
   endfunction

endpackage

// File: rtl/wfg_drive_pat_seq_skid.sv
// One-entry prefetch buffer between the pattern AXI-Stream and the sequencer.
// Only instantiated when WFG_DRIVE_PAT_SKID_EN is defined.
module wfg_drive_pat_skid #(
   parameter int unsigned WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             i_flush,
   input  logic             i_allow,
   input  logic             i_pop,
   input  logic             i_tvalid,
   input  logic [WIDTH-1:0] i_tdata,
   output logic             o_tready,
   output logic             o_valid,
   output logic [WIDTH-1:0] o_data
);

   logic             r_valid;
   logic [WIDTH-1:0] r_data;
   logic             w_push;

   // Ready depends only on flops, so upstream sees no combinational path.
   assign o_tready = i_allow && !r_valid;
   assign w_push   = i_tvalid && o_tready;

   // Push and pop never coincide: push needs an empty buffer, pop a full one.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_valid <= 1'b0;
         r_data  <= '0;
      end else if (i_flush) begin
         r_valid <= 1'b0;
         r_data  <= '0;
      end else if (i_pop && r_valid) begin
         r_valid <= 1'b0;
      end else if (w_push) begin
         r_valid <= 1'b1;
         r_data  <= i_tdata;
      end
   end

   assign o_valid = r_valid;
   assign o_data  = r_data;

endmodule

// File: rtl/wfg_drive_pat_seq.sv
// Drive-pattern sequencer: loads one pattern word per sync and counts subcycles.
// Optional prefetch buffer enabled by defining WFG_DRIVE_PAT_SKID_EN.
module wfg_drive_pat_seq
   import wfg_drive_pat_pkg::*;
#(
   parameter int unsigned CHANNELS = 32
) (
   input  logic                              clk,
   input  logic                              rst_n,
   input  logic                              ctrl_en_q_i,
   input  logic                              wfg_pat_sync_i,
   input  logic                              wfg_pat_subcycle_i,
   input  logic [CHANNELS-1:0]               wfg_axis_tdata_i,
   input  logic                              wfg_axis_tvalid_i,
   output logic                              wfg_axis_tready_o,
   output logic [WFG_PAT_SUBCYCLE_CNT_W-1:0] pat_subcycle_cnt_o,
   output logic [CHANNELS-1:0]               axis_data_ff_o,
   output logic                              active_o,
   output logic                              underflow_o,
   input  logic                              clr_underflow_i
);

   wfg_drive_pat_seq_state_t            r_state;
   logic [WFG_PAT_SUBCYCLE_CNT_W-1:0]   r_cnt;
   logic [CHANNELS-1:0]                 r_data;
   logic                                r_active;
   logic                                r_underflow;

   logic                                w_avail;
   logic [CHANNELS-1:0]                 w_word;
   logic                                w_uf_set;

`ifdef WFG_DRIVE_PAT_SKID_EN
   logic                w_buf_valid;
   logic [CHANNELS-1:0] w_buf_data;

   wfg_drive_pat_skid #(
      .WIDTH (CHANNELS)
   ) u_skid (
      .clk      (clk),
      .rst_n    (rst_n),
      .i_flush  (!ctrl_en_q_i),
      .i_allow  (r_state != IDLE),
      .i_pop    (wfg_pat_sync_i && (r_state != IDLE)),
      .i_tvalid (wfg_axis_tvalid_i),
      .i_tdata  (wfg_axis_tdata_i),
      .o_tready (wfg_axis_tready_o),
      .o_valid  (w_buf_valid),
      .o_data   (w_buf_data)
   );

   // A word that arrives in the sync cycle only fills the buffer.
   assign w_avail = w_buf_valid;
   assign w_word  = w_buf_data;
`else
   // Without a buffer the word is taken straight off the bus at sync.
   assign wfg_axis_tready_o = (r_state != IDLE) && wfg_pat_sync_i;
   assign w_avail           = wfg_axis_tvalid_i;
   assign w_word            = wfg_axis_tdata_i;
`endif

   assign w_uf_set = ctrl_en_q_i && (r_state == RUN) && wfg_pat_sync_i && !w_avail;

   // State, data and count update on the same edge so drivers see a coherent pair.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state  <= IDLE;
         r_cnt    <= '0;
         r_data   <= '0;
         r_active <= 1'b0;
      end else if (!ctrl_en_q_i) begin
         r_state  <= IDLE;
         r_cnt    <= '0;
         r_data   <= '0;
         r_active <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               r_state  <= WAIT_SYNC;
               r_cnt    <= '0;
               r_data   <= '0;
               r_active <= 1'b0;
            end
            WAIT_SYNC, RUN: begin
               if (wfg_pat_sync_i) begin
                  r_cnt <= '0;
                  if (w_avail) begin
                     r_data   <= w_word;
                     r_state  <= RUN;
                     r_active <= 1'b1;
                  end
               end else if (wfg_pat_subcycle_i) begin
                  r_cnt <= sat_inc(r_cnt);
               end
            end
            default: begin
               r_state  <= IDLE;
               r_cnt    <= '0;
               r_data   <= '0;
               r_active <= 1'b0;
            end
         endcase
      end
   end

   // Sticky underflow; a new event beats a simultaneous clear.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_underflow <= 1'b0;
      end else begin
         r_underflow <= w_uf_set || (r_underflow && !clr_underflow_i);
      end
   end

   assign pat_subcycle_cnt_o = r_cnt;
   assign axis_data_ff_o     = r_data;
   assign active_o           = r_active;
   assign underflow_o        = r_underflow;

endmodule

// File: doc/wfg_drive_pat_seq.md
# wfg_drive_pat_seq

Pattern sequencer for the drive-pattern path. It accepts pattern words from the upstream AXI-Stream and loads one word per pattern cycle on the sync pulse. It generates the subcycle count that the per-channel pattern drivers compare against their begin/end configuration. It feeds each channel driver its data bit (`axis_data_ff_o[n]`) and the shared `pat_subcycle_cnt_o`.

## Interface
- `CHANNELS`, default 32: number of driven channels; equals the AXI-Stream data width.
- `clk` input 1: system clock.
- `rst_n` input 1: reset, asynchronous, active-low.
- `ctrl_en_q_i` input 1: block enable from the register file.
- `wfg_pat_sync_i` input 1: single-cycle pulse marking the start of a pattern cycle.
- `wfg_pat_subcycle_i` input 1: single-cycle pulse marking each subcycle boundary.
- `wfg_axis_tdata_i` input CHANNELS: pattern word; bit n drives channel n.
- `wfg_axis_tvalid_i` input 1: upstream word valid.
- `wfg_axis_tready_o` output 1: sequencer accepts the word.
- `pat_subcycle_cnt_o` output 8: subcycle index within the current pattern cycle.
- `axis_data_ff_o` output CHANNELS: active pattern word, to the channel drivers.
- `active_o` output 1: high while in RUN.
- `underflow_o` output 1: sticky flag; a sync arrived with no word available.
- `clr_underflow_i` input 1: pulse that clears `underflow_o`.

## Operation
- States: IDLE, WAIT_SYNC, RUN. State is encoded in a flop.
- **IDLE**
  - Entered at reset, and from any state one cycle after `ctrl_en_q_i`=0.
  - Behaviour in IDLE: cnt=0, data=0, `tready`=0, `active_o`=0.
  - Exit: go to WAIT_SYNC when `ctrl_en_q_i`=1.
- **WAIT_SYNC**
  - On sync with a word available: load the word, set cnt=0, go to RUN.
  - On sync with no word: stay in WAIT_SYNC. Underflow is not flagged.
- **RUN**
  - On sync with a word available: load the word and set cnt=0.
  - On sync with no word: hold the previous data, set cnt=0, set `underflow_o`.
- Subcycle counting (WAIT_SYNC and RUN, no sync that cycle):
  - Each `wfg_pat_subcycle_i` pulse increments cnt.
  - cnt saturates at 255 and never wraps.
- Simultaneous sync and subcycle pulse: sync wins, cnt=0.
- Disable mid-cycle (`ctrl_en_q_i` falls):
  - Next edge returns the block to IDLE: cnt=0, data=0, any buffered word dropped.
  - `underflow_o` is retained.
- `underflow_o`:
  - Cleared by `clr_underflow_i`.
  - If set and clear occur in the same cycle, set wins.
- "Word available" is defined under Configuration.
- Handshake: a transfer occurs when `tvalid`&&`tready` are both high at a rising edge.
  - Upstream holds tdata stable while tvalid=1 and tready=0.

## Timing
- Reset values: `pat_subcycle_cnt_o`=0, `axis_data_ff_o`=0, `wfg_axis_tready_o`=0, `active_o`=0, `underflow_o`=0.
- All outputs except `wfg_axis_tready_o` are registered.
- New word and cnt=0 are visible on outputs 1 cycle after the sync edge.
- Each cnt increment is visible 1 cycle after the subcycle pulse.
- Data and cnt change on the same edge, so the channel drivers see a coherent pair.
- `active_o` rises in the same cycle as the first loaded word appears.

## Configuration
- Macro: `WFG_DRIVE_PAT_SKID_EN`.
- **Defined:** adds a one-entry prefetch buffer.
  - `tready_o` = (state≠IDLE) && !buf_valid, driven purely from flops.
  - A handshake fills the buffer. "Word available" means buf_valid.
  - Sync moves the buffer into data and empties it; `tready` rises again the next cycle.
  - A handshake in the same cycle as sync with an empty buffer fills the buffer only; that sync counts as no word.
- **Undefined:** no buffer.
  - `tready_o` = (state≠IDLE) && `wfg_pat_sync_i`, combinational.
  - "Word available" means `tvalid_i` during the sync cycle.
  - The word is loaded directly.

## Structure
- Shared package `wfg_drive_pat_pkg` holds:
  - the state enum `wfg_drive_pat_seq_state_t` (IDLE, WAIT_SYNC, RUN);
  - `WFG_PAT_SUBCYCLE_CNT_W`=8;
  - `WFG_PAT_SUBCYCLE_CNT_MAX`=8'hFF.
- Natural sub-module: `wfg_drive_pat_skid`, the one-entry buffer, instantiated only under `WFG_DRIVE_PAT_SKID_EN`.
- The subcycle counter and FSM stay inline.

## Test plan
- **Reset:** assert `rst_n`=0 mid-RUN with cnt=5 and data=32'hA5A5A5A5. Required: all outputs 0 immediately; IDLE after release.
- **Basic cycle:** enable, tvalid with tdata=32'h0000_00F0, sync, then 3 subcycle pulses. Required: data=32'hF0 and cnt=0 one cycle after sync; cnt=3 after the third pulse; `active_o`=1.
- **Saturation and collision:** 300 subcycle pulses with no sync. Required: cnt stops at 255. Then sync and subcycle in the same cycle. Required: cnt=0.
- **Underflow:** in RUN, sync with tvalid=0. Required: data held, cnt=0, `underflow_o`=1. Pulse `clr_underflow_i`. Required: 0. Set and clear together. Required: stays 1.
- **Disable:** drop `ctrl_en_q_i` at cnt=7. Required: next cycle cnt=0, data=0, tready=0, `underflow_o` unchanged, buffered word discarded.
- **Skid (macro defined):** handshake 32'h1 before the first sync. Required: tready falls. At sync: data=32'h1, tready=1 the next cycle. A handshake coinciding with a sync on an empty buffer. Required: underflow set.
